// File: rtl/mmio_data_ram.sv
// mmio_data_ram: word-addressed data RAM for the J17 CPU with two
// memory-mapped words folded in: a read-only button status word (sync,
// debounce, sticky press flag cleared on read) and a display register that
// drives one active-low hex seven-segment digit.
module mmio_data_ram #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 32,
  parameter int SEG_ADDR  = 0,
  parameter int BTN_ADDR  = 1,
  parameter int DB_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              write,
  input  logic              read,
  input  logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] result,
  output logic [6:0]        seg,
  output logic              addr_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] SEG_A    = ADDR_W'(SEG_ADDR);
  localparam logic [ADDR_W-1:0] BTN_A    = ADDR_W'(BTN_ADDR);
  localparam logic [CW-1:0]     CNT_LAST = CW'(DB_CYCLES - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] display;
  logic              sync1, sync2, level, press;
  logic [CW-1:0]     count;

  logic          is_seg, is_btn, wr_ok, differ, settle, rise, clr;
  logic [IW-1:0] idx;

  assign addr_err = ({1'b0, addr} >= DEPTH_A);
  assign is_seg   = (addr == SEG_A);
  assign is_btn   = (addr == BTN_A);
  assign idx      = addr[IW-1:0];
  // Status word is read-only; out-of-range writes are dropped rather than aliased.
  assign wr_ok    = write & ~addr_err & ~is_btn;

  // Debounce: level follows sync2 only after DB_CYCLES consecutive disagreeing samples.
  assign differ = (sync2 != level);
  assign settle = differ && (count == CNT_LAST);
  assign rise   = settle & sync2;
  assign clr    = read & is_btn;

  // Button synchroniser, debouncer and sticky press flag (set beats clear).
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      count <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
      if (!differ) begin
        count <= '0;
      end else if (settle) begin
        level <= sync2;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
      if (rise)     press <= 1'b1;
      else if (clr) press <= 1'b0;
    end
  end

  // Display register; all DATA_W bits are kept so software reads back what it wrote.
  always_ff @(posedge clock) begin
    if (reset)                display <= '0;
    else if (wr_ok && is_seg) display <= value;
  end

  // Plain RAM storage, deliberately not reset; reset still blocks a same-cycle write.
  always_ff @(posedge clock) begin
    if (!reset && wr_ok && !is_seg) mem[idx] <= value;
  end

  // Combinational read mux over RAM and the two mapped words.
  always_comb begin
    result = '0;
    if (addr_err)    result = '0;
    else if (is_btn) result = {{(DATA_W-2){1'b0}}, press, level};
    else if (is_seg) result = display;
    else             result = mem[idx];
  end

  // Hex digit decode, segments {a..g}, driven active-low.
  always_comb begin
    logic [6:0] pat;
    pat = 7'b0000000;
    case (display[3:0])
      4'h0: pat = 7'b1111110;
      4'h1: pat = 7'b0110000;
      4'h2: pat = 7'b1101101;
      4'h3: pat = 7'b1111001;
      4'h4: pat = 7'b0110011;
      4'h5: pat = 7'b1011011;
      4'h6: pat = 7'b1011111;
      4'h7: pat = 7'b1110000;
      4'h8: pat = 7'b1111111;
      4'h9: pat = 7'b1111011;
      4'hA: pat = 7'b1110111;
      4'hB: pat = 7'b0011111;
      4'hC: pat = 7'b1001110;
      4'hD: pat = 7'b0111101;
      4'hE: pat = 7'b1001111;
      4'hF: pat = 7'b1000111;
      default: pat = 7'b0000000;
    endcase
    seg = ~pat;
  end

endmodule

// File: tb/tb_mmio_data_ram.sv
// Scoreboard bench for mmio_data_ram: stimulus pushes expected read data,
// seg and addr_err from a behavioural model; a negedge monitor compares.
module tb_mmio_data_ram;
  localparam int DW = 32, AW = 10, DEPTH = 32, SEG = 0, BTN = 1, DB = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [DW-1:0] value = '0;
  logic [DW-1:0] result;
  logic [6:0]    seg;
  logic          addr_err;

  mmio_data_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .SEG_ADDR(SEG),
                  .BTN_ADDR(BTN), .DB_CYCLES(DB)) dut (
    .clock(clock), .reset(reset), .in(in), .addr(addr), .write(write),
    .read(read), .value(value), .result(result), .seg(seg), .addr_err(addr_err));

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [int];
  logic [31:0] m_disp;
  bit          m_s1, m_s2, m_level, m_press;
  bit          hist[$];   // recent synchronised samples since last level change

  always @(posedge clock) begin
    bit s, all_diff, rose;
    int a;
    a = int'(addr);
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0; m_disp = 0;
      hist.delete();
    end else begin
      s = m_s2; m_s2 = m_s1; m_s1 = in;
      hist.push_back(s);
      if (hist.size() > DB) void'(hist.pop_front());
      rose = 0;
      if (hist.size() == DB) begin
        all_diff = 1;
        foreach (hist[i]) if (hist[i] == m_level) all_diff = 0;
        if (all_diff) begin
          m_level = ~m_level;
          rose = m_level;
          hist.delete();
        end
      end
      if (rose) m_press = 1;
      else if (read && a == BTN) m_press = 0;
      if (write && a < DEPTH && a != BTN) begin
        if (a == SEG) m_disp = value;
        else m_mem[a] = value;
      end
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'h0: p = 7'b1111110; 4'h1: p = 7'b0110000; 4'h2: p = 7'b1101101; 4'h3: p = 7'b1111001;
      4'h4: p = 7'b0110011; 4'h5: p = 7'b1011011; 4'h6: p = 7'b1011111; 4'h7: p = 7'b1110000;
      4'h8: p = 7'b1111111; 4'h9: p = 7'b1111011; 4'hA: p = 7'b1110111; 4'hB: p = 7'b0011111;
      4'hC: p = 7'b1001110; 4'hD: p = 7'b0111101; 4'hE: p = 7'b1001111; default: p = 7'b1000111;
    endcase
    return ~p;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] r;
    logic [6:0]  s;
    logic        e;
    int          a;
    string       tag;
  } exp_t;
  exp_t  sb[$];
  bit    chk_req = 0;
  int    n_checks = 0, n_fail = 0;
  string tag = "reset";

  always @(negedge clock) begin
    exp_t x;
    if (chk_req) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: DUT output present with no expected entry");
      end else begin
        x = sb.pop_front();
        if (result !== x.r || seg !== x.s || addr_err !== x.e) begin
          n_fail++;
          $display("FAIL %s addr=%0d: got result=%h seg=%b err=%b, expected result=%h seg=%b err=%b",
                   x.tag, x.a, result, seg, addr_err, x.r, x.s, x.e);
        end
      end
    end
  end

  // One clock of stimulus; inputs change 2 time units after the edge.
  task automatic cyc(input int a, input bit w, input bit r, input logic [31:0] v, input bit chk);
    exp_t x;
    @(posedge clock);
    #2;
    addr = AW'(a); write = w; read = r; value = v;
    if (chk) begin
      x.a = a; x.tag = tag;
      x.e = (a >= DEPTH);
      if (a >= DEPTH)   x.r = '0;
      else if (a == BTN) x.r = {30'b0, m_press, m_level};
      else if (a == SEG) x.r = m_disp;
      else               x.r = m_mem.exists(a) ? m_mem[a] : 32'hx;
      x.s = seg_of(m_disp[3:0]);
      sb.push_back(x);
    end
    chk_req = chk;
  endtask

  initial begin
    // reset and check mapped words
    reset = 1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    reset = 0;
    cyc(SEG, 0, 0, 0, 1);
    cyc(BTN, 0, 0, 0, 1);

    // fill every RAM word so later reads are defined
    tag = "fill";
    for (int a = 0; a < DEPTH; a++) cyc(a, 1, 0, $urandom, 0);

    // RAM write/read and out-of-range handling
    tag = "ram";
    cyc(5, 1, 0, 32'hDEADBEEF, 0);
    cyc(5, 0, 0, 0, 1);
    cyc(8, 1, 0, 32'h0000A5A5, 0);
    cyc(40, 1, 0, 32'h00001234, 1);
    cyc(40, 0, 0, 0, 1);
    cyc(8, 0, 0, 0, 1);

    // display register
    tag = "seg";
    cyc(SEG, 1, 0, 32'h0000000B, 0);
    cyc(SEG, 0, 0, 0, 1);
    cyc(SEG, 1, 0, 32'hFFFFFFF3, 0);
    cyc(SEG, 0, 0, 0, 1);

    // clean press, read-clear, release
    tag = "press";
    in = 1;
    for (int i = 0; i < 20; i++) cyc(BTN, 0, 0, 0, 1);
    tag = "rdclr";
    cyc(BTN, 0, 1, 0, 1);
    cyc(BTN, 0, 0, 0, 1);
    tag = "release";
    in = 0;
    for (int i = 0; i < 20; i++) cyc(BTN, 0, 0, 0, 1);

    // short glitch must be rejected
    tag = "glitch";
    in = 1;
    for (int i = 0; i < 10; i++) cyc(BTN, 0, 0, 0, 1);
    in = 0;
    for (int i = 0; i < 25; i++) cyc(BTN, 0, 0, 0, 1);

    // held press interrupted by reset is re-qualified from scratch
    tag = "rst_mid";
    in = 1;
    for (int i = 0; i < 8; i++) cyc(BTN, 0, 0, 0, 1);
    reset = 1;
    cyc(BTN, 0, 0, 0, 1);
    reset = 0;
    for (int i = 0; i < 22; i++) cyc(BTN, 0, 0, 0, 1);

    // read-clear on every edge, including the rising one: set wins there
    tag = "set_wins";
    in = 0;
    for (int i = 0; i < 20; i++) cyc(BTN, 0, 0, 0, 0);
    in = 1;
    for (int i = 0; i < 22; i++) cyc(BTN, 0, 1, 0, 1);
    cyc(BTN, 0, 0, 0, 1);

    // writes to the status word are ignored
    tag = "btn_wr";
    cyc(BTN, 1, 0, 32'h000000FF, 1);
    cyc(BTN, 0, 0, 0, 1);

    // randomized traffic
    tag = "random";
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(29) == 0) in = ~in;
      reset = ($urandom_range(199) == 0);
      cyc($urandom_range(47), $urandom_range(2) == 0, $urandom_range(2) == 0, $urandom, 1);
    end
    reset = 0;

    cyc(0, 0, 0, 0, 0);
    @(negedge clock);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mmio_data_ram.md
Name: mmio_data_ram

Overview:
- Parametrised data memory for the J17 CPU with memory-mapped I/O folded into the address space.
- Word-addressed RAM of DEPTH x DATA_W, with:
  - a read-only button status word (built-in synchroniser, debouncer and sticky press flag, cleared on read);
  - a display register driving one active-low hex seven-segment digit.
- Sits on the CPU data-memory port. Replaces the fixed 32-bit RAM with hard-wired button and display words.

Parameters:
- DATA_W, 32: word width in bits (min 8).
- ADDR_W, 10: address bus width.
- DEPTH, 32: number of words; legal addresses 0..DEPTH-1 (DEPTH <= 2**ADDR_W).
- SEG_ADDR, 0: address of the display register (< DEPTH).
- BTN_ADDR, 1: address of the button status word (< DEPTH, != SEG_ADDR).
- DB_CYCLES, 16: consecutive stable cycles required to accept a button change (>= 2).

Ports:
- clock, input, 1: single clock; all state updates on rising edge.
- reset, input, 1: synchronous, active-high.
- in, input, 1: raw asynchronous push-button.
- addr, input, ADDR_W: word address for read/write.
- write, input, 1: store value at addr on this edge.
- read, input, 1: read strobe; only side effect is clearing the press flag.
- value, input, DATA_W: write data.
- result, output, DATA_W: combinational read data at addr.
- seg, output, 7: {a,b,c,d,e,f,g}, active-low.
- addr_err, output, 1: combinational; 1 when addr >= DEPTH.

Behaviour:
- Reset (synchronous, while reset=1 at an edge):
  - Synchroniser flops = 0, debounced level = 0, debounce count = 0, press flag = 0, display register = 0.
  - seg = 7'b0000001 ("0").
  - RAM words are NOT reset; bench must write before reading them.
  - reset has priority over write/read in the same cycle.
- RAM:
  - write=1, addr < DEPTH, addr != BTN_ADDR: word[addr] <= value at the edge.
  - result = word[addr] combinationally, so a write is visible the cycle after.
  - addr == SEG_ADDR maps to the display register, which reads back all DATA_W bits.
  - addr >= DEPTH: write ignored, result = 0, addr_err = 1.
- Button path:
  - `in` passes through two flops (sync1 -> sync2).
  - If sync2 != level: count increments. When count == DB_CYCLES-1 and sync2 still differs, level <= sync2 and count <= 0.
  - If sync2 == level: count <= 0, so glitches shorter than DB_CYCLES cycles are rejected.
  - Latency: a clean edge on `in` reaches level exactly 2 + DB_CYCLES rising edges later.
- Press flag:
  - Set on the edge where level goes 0->1.
  - Cleared on an edge with read=1 and addr == BTN_ADDR.
  - Set and clear on the same edge: set wins.
- BTN_ADDR read value: {zeros, press, level}, i.e. bit1 = press, bit0 = level, upper bits 0.
  - Writes to BTN_ADDR are ignored.
  - read has no effect at any other address.
- Display:
  - seg = ~pattern(display[3:0]), pattern {a..g}:
    - 0:1111110, 1:0110000, 2:1101101, 3:1111001
    - 4:0110011, 5:1011011, 6:1011111, 7:1110000
    - 8:1111111, 9:1111011, A:1110111, b:0011111
    - C:1001110, d:0111101, E:1001111, F:1000111
  - Upper display bits are stored but do not affect seg.
- Reset mid-operation: an in-progress debounce count is discarded; a held button is re-qualified from scratch after reset releases.

Test Plan:
- Reset, then read SEG_ADDR and BTN_ADDR -> result=0 for both, seg=7'b0000001, addr_err=0.
- Write 32'hDEADBEEF to addr 5, next cycle addr=5 -> result=32'hDEADBEEF. Write 32'h1234 to addr 40 (DEPTH=32) -> addr_err=1, result=0, addr 8 (aliased low bits) unchanged.
- Write 32'h0000000B to SEG_ADDR -> seg=~7'b0011111=7'b1100000 next cycle. Write 32'hFFFFFFF3 -> seg=7'b0000110, SEG_ADDR reads 32'hFFFFFFF3.
- Drive in=1 (DB_CYCLES=16) -> BTN_ADDR reads 0 through edge 17, reads 32'h3 after edge 18. Pulse read at BTN_ADDR -> reads 32'h1. Release in -> reads 0 after 18 edges.
- Drive in=1 for 10 cycles then 0 -> BTN_ADDR stays 0 throughout (glitch rejected). Then press held with reset pulsed at cycle 8 -> level rises 18 edges after reset deasserts.
- Arrange read-clear at BTN_ADDR on the same edge level rises -> press stays 1 (reads 32'h3). Write 32'hFF to BTN_ADDR -> ignored, status unchanged.
